field_op_scheduler: RTL and testbench

FIELD_OP_SCHEDULER -- requirements
Module: field_op_scheduler

---
 rtl/field_op_scheduler_pkg.sv | 39 +++
 rtl/field_op_scheduler_prog_rom.sv | 31 +++
 rtl/field_op_scheduler.sv | 144 ++++++++++++++
 tb/tb_field_op_scheduler.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/field_op_scheduler_pkg.sv
// Shared encodings for the field-op scheduler: opcodes, FSM states and the
// instruction word layout used by both the scheduler and its program store.
package field_op_scheduler_pkg;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_SQR = 2'd1,
    OP_ADD = 2'd2,
    OP_END = 2'd3
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  localparam int INSTR_W = 9;
  localparam int ADDR_W  = 6;

  // Field order fixes the bit positions: op[8:7], slot[6:4], rep[3:0].
  typedef struct packed {
    opcode_e    op;
    logic [2:0] slot;
    logic [3:0] rep;
  } instr_t;

  function automatic instr_t mk_instr(opcode_e op, logic [2:0] slot, logic [3:0] rep);
    instr_t i;
    i.op   = op;
    i.slot = slot;
    i.rep  = rep;
    return i;
  endfunction

endpackage

// File: rtl/field_op_scheduler_prog_rom.sv
// Program store: 4 programs x 16 instructions, combinational read.
// Unlisted locations read as END, except program 2 which deliberately has none.
module sched_prog_rom
  import field_op_scheduler_pkg::*;
(
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [INSTR_W-1:0] data_o
);

  instr_t data;

  always_comb begin
    data = mk_instr(OP_END, 3'd0, 4'd0);
    case (addr_i[5:4])
      2'd0: begin
        if (addr_i[3:0] == 4'd0) data = mk_instr(OP_MUL, 3'd1, 4'd0);
      end
      2'd1: begin
        if (addr_i[3:0] == 4'd0) data = mk_instr(OP_SQR, 3'd2, 4'd3);
      end
      2'd2: data = mk_instr(OP_ADD, addr_i[2:0], 4'd0);
      default: begin
        if (addr_i[3:0] == 4'd0)      data = mk_instr(OP_ADD, 3'd3, 4'd1);
        else if (addr_i[3:0] == 4'd1) data = mk_instr(OP_MUL, 3'd4, 4'd0);
      end
    endcase
  end

  assign data_o = data;

endmodule

// File: rtl/field_op_scheduler.sv
// Sequences primitive field ops (mul/sqr/add) from a small program store,
// handshaking with the primitive controller via prim_rst/prim_done.
module field_op_scheduler
  import field_op_scheduler_pkg::*;
#(
  parameter int WDOG_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] prog_sel,
  input  logic       prim_done,
  output logic       prim_rst,
  output logic [1:0] prim_mode,
  output logic [2:0] prim_slot,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] op_count,
  output logic [2:0] state
);

  localparam int WDOG_W = (WDOG_MAX < 2) ? 1 : $clog2(WDOG_MAX);

  state_e              state_q, state_d;
  logic [1:0]          prog_sel_q, prog_sel_d;
  logic [3:0]          pc_q, pc_d;
  logic [3:0]          rep_q, rep_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic [7:0]          op_cnt_q, op_cnt_d;
  logic                err_q, err_d;
  logic [1:0]          mode_q, mode_d;
  logic [2:0]          slot_q, slot_d;
  logic                prim_rst_q;
  logic [INSTR_W-1:0]  rom_data;
  instr_t              rom_instr;

  sched_prog_rom u_rom (
    .addr_i (({prog_sel_q, pc_q})),
    .data_o (rom_data)
  );

  assign rom_instr = instr_t'(rom_data);

  always_comb begin
    state_d    = state_q;
    prog_sel_d = prog_sel_q;
    pc_d       = pc_q;
    rep_d      = rep_q;
    wdog_d     = wdog_q;
    op_cnt_d   = op_cnt_q;
    err_d      = err_q;
    mode_d     = mode_q;
    slot_d     = slot_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          prog_sel_d = prog_sel;
          pc_d       = 4'd0;
          op_cnt_d   = 8'd0;
          err_d      = 1'b0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (rom_instr.op == OP_END) begin
          state_d = ST_FINISH;
        end else begin
          // Op fields are captured here so they are already valid in ISSUE.
          mode_d  = rom_instr.op;
          slot_d  = rom_instr.slot;
          rep_d   = rom_instr.rep;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (prim_done) begin
          if (op_cnt_q != 8'hFF) op_cnt_d = op_cnt_q + 8'd1;
          state_d = ST_NEXT;
        end else if (wdog_q == WDOG_W'(WDOG_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      ST_NEXT: begin
        if (rep_q != 4'd0) begin
          rep_d   = rep_q - 4'd1;
          state_d = ST_ISSUE;
        end else if (pc_q == 4'd15) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          pc_d    = pc_q + 4'd1;
          state_d = ST_FETCH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      prog_sel_q <= 2'd0;
      pc_q       <= 4'd0;
      rep_q      <= 4'd0;
      wdog_q     <= '0;
      op_cnt_q   <= 8'd0;
      err_q      <= 1'b0;
      mode_q     <= 2'd0;
      slot_q     <= 3'd0;
      prim_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      prog_sel_q <= prog_sel_d;
      pc_q       <= pc_d;
      rep_q      <= rep_d;
      wdog_q     <= wdog_d;
      op_cnt_q   <= op_cnt_d;
      err_q      <= err_d;
      mode_q     <= mode_d;
      slot_q     <= slot_d;
      // The primitive is released only for cycles spent in WAIT.
      prim_rst_q <= (state_d != ST_WAIT);
    end
  end

  assign prim_rst  = prim_rst_q;
  assign prim_mode = mode_q;
  assign prim_slot = slot_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done      = (state_q == ST_FINISH);
  assign err       = err_q;
  assign op_count  = op_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_field_op_scheduler.sv
// Scoreboard bench for field_op_scheduler: expected run results are queued at
// start and compared when the done pulse appears.
module tb_field_op_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] prog_sel = 2'd0;
  logic       prim_done = 1'b0;
  logic       prim_rst;
  logic [1:0] prim_mode;
  logic [2:0] prim_slot;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] op_count;
  logic [2:0] state;

  always #5 clk = ~clk;

  field_op_scheduler #(.WDOG_MAX(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prog_sel  (prog_sel),
    .prim_done (prim_done),
    .prim_rst  (prim_rst),
    .prim_mode (prim_mode),
    .prim_slot (prim_slot),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .op_count  (op_count),
    .state     (state)
  );

  typedef struct {
    int ops;
    int err;
    int lat;
    int win;
    int mode;
    int slot;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // plat: WAIT cycles before prim_done is raised (<=0 means never).
  // poke: raise prim_done in ISSUE and re-request start while busy.
  task automatic run_prog(input logic [1:0] sel, input int plat, input bit poke, input exp_t e);
    int   lowcnt, win, fmode, fslot, lat;
    bit   prev_rst, got;
    exp_t x;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b1;
    prog_sel = sel;
    win = 0; lowcnt = 0; prev_rst = 1'b1; got = 1'b0; fmode = -1; fslot = -1; lat = 0;
    for (int cyc = 1; cyc <= 400 && !got; cyc++) begin
      @(negedge clk);
      start    = poke && (cyc == 5);
      prog_sel = (poke && cyc == 5) ? ~sel : sel;
      if (!prim_rst) begin
        if (prev_rst) begin
          win++;
          lowcnt = 0;
          if (win == 1) begin
            fmode = int'(prim_mode);
            fslot = int'(prim_slot);
          end
        end
        lowcnt++;
      end
      prev_rst  = prim_rst;
      prim_done = !prim_rst && plat > 0 && lowcnt == plat;
      if (poke && cyc == 2) begin
        chk("poke_in_issue", 32'(state), 32'd2);
        prim_done = 1'b1;
      end
      if (done) begin
        got = 1'b1;
        lat = cyc;
      end
    end
    prim_done = 1'b0;
    start     = 1'b0;
    x = sb.pop_front();
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("latency",    32'(lat),      32'(x.lat));
      chk("op_count",   32'(op_count), 32'(x.ops));
      chk("err",        32'(err),      32'(x.err));
      chk("windows",    32'(win),      32'(x.win));
      chk("first_mode", 32'(fmode),    32'(x.mode));
      chk("first_slot", 32'(fslot),    32'(x.slot));
      chk("busy_at_done", 32'(busy),   32'd0);
      chk("prim_rst_at_done", 32'(prim_rst), 32'd1);
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(done),     32'd0);
    chk("back_to_idle",   32'(state),    32'd0);
    chk("op_count_hold",  32'(op_count), 32'(x.ops));
    chk("err_hold",       32'(err),      32'(x.err));
  endtask

  initial begin
    int ndone;
    repeat (3) @(negedge clk);
    chk("rst_state",     32'(state),     32'd0);
    chk("rst_prim_rst",  32'(prim_rst),  32'd1);
    chk("rst_prim_mode", 32'(prim_mode), 32'd0);
    chk("rst_prim_slot", 32'(prim_slot), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_op_count",  32'(op_count),  32'd0);
    rst = 1'b0;

    run_prog(2'd0,  8, 1'b0, '{1,  0, 13,  1,  0, 1});
    run_prog(2'd1,  3, 1'b0, '{4,  0, 23,  4,  1, 2});
    run_prog(2'd3,  1, 1'b0, '{3,  0, 13,  3,  2, 3});
    run_prog(2'd2,  2, 1'b0, '{16, 1, 81,  16, 2, 0});
    run_prog(2'd0, -1, 1'b0, '{0,  1, 258, 1,  0, 1});
    run_prog(2'd0,  8, 1'b1, '{1,  0, 13,  1,  0, 1});

    // Reset during the second WAIT of the squaring chain.
    @(negedge clk);
    start    = 1'b1;
    prog_sel = 2'd1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      start     = 1'b0;
      prim_done = (cyc == 5);
    end
    prim_done = 1'b0;
    chk("pre_rst_state", 32'(state),    32'd3);
    chk("pre_rst_ops",   32'(op_count), 32'd1);
    chk("pre_rst_mode",  32'(prim_mode), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_state",     32'(state),     32'd0);
    chk("mid_rst_prim_rst",  32'(prim_rst),  32'd1);
    chk("mid_rst_prim_mode", 32'(prim_mode), 32'd0);
    chk("mid_rst_prim_slot", 32'(prim_slot), 32'd0);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    chk("mid_rst_done",      32'(done),      32'd0);
    chk("mid_rst_err",       32'(err),       32'd0);
    chk("mid_rst_op_count",  32'(op_count),  32'd0);
    ndone = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_done_after_rst", 32'(ndone), 32'd0);
    chk("idle_after_rst",    32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
